gshare_predictor: RTL

GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

---
 rtl/gshare_predictor_pkg.sv | 22 ++
 rtl/gshare_ghr.sv | 50 +++++
 rtl/gshare_predictor.sv | 109 ++++++++++
 3 files changed

// File: rtl/gshare_predictor_pkg.sv
// Shared predictor definitions: 2-bit counter encodings, init FSM states and
// the saturating-counter next-state function.
`timescale 1ns/1ps
package gshare_predictor_pkg;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  typedef logic [0:0] fsm_state_t;
  localparam fsm_state_t ST_INIT = 1'b0;
  localparam fsm_state_t ST_RUN  = 1'b1;

  function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
    if (taken) begin
      return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
    end
    return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/gshare_ghr.sv
// Global history register: speculative shift of predicted directions and
// recovery from committed history. Held at zero unless GSHARE_PREDICTOR_GHIST_EN.
`timescale 1ns/1ps
module gshare_ghr #(
  parameter int HIST_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_en,
  input  logic                  shift_bit,
  input  logic                  recover,
  input  logic [HIST_WIDTH-1:0] recover_hist,
  input  logic                  recover_taken,
  output logic [HIST_WIDTH-1:0] ghr
);

`ifdef GSHARE_PREDICTOR_GHIST_EN
  logic [HIST_WIDTH-1:0] ghr_reg;
  logic [HIST_WIDTH-1:0] recover_value;
  logic [HIST_WIDTH-1:0] shift_value;

  generate
    if (HIST_WIDTH == 1) begin : g_w1
      assign recover_value = recover_taken;
      assign shift_value   = shift_bit;
    end else begin : g_wn
      assign recover_value = {recover_hist[HIST_WIDTH-2:0], recover_taken};
      assign shift_value   = {ghr_reg[HIST_WIDTH-2:0], shift_bit};
    end
  endgenerate

  // Recovery wins over a same-cycle speculative shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_reg <= '0;
    end else if (recover) begin
      ghr_reg <= recover_value;
    end else if (shift_en) begin
      ghr_reg <= shift_value;
    end
  end

  assign ghr = ghr_reg;
`else
  logic unused_in;
  assign unused_in = ^{clk, rst, shift_en, shift_bit, recover, recover_hist, recover_taken};
  assign ghr = '0;
`endif

endmodule

// File: rtl/gshare_predictor.sv
// Gshare/bimodal branch direction predictor with a power-up PHT sweep.
// Define GSHARE_PREDICTOR_GHIST_EN for history-hashed indexing; otherwise bimodal.
`timescale 1ns/1ps
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int PHT_WIDTH  = 12,
  parameter int HIST_WIDTH = 8
) (
  input  logic                  clockIn,
  input  logic                  resetIn,
  input  logic                  readyIn,
  input  logic                  predValid,
  input  logic [31:0]           instrAddr,
  output logic                  jump,
  output logic [HIST_WIDTH-1:0] predHist,
  input  logic                  updateValid,
  input  logic [31:0]           updateInstr,
  input  logic [HIST_WIDTH-1:0] updateHist,
  input  logic                  taken,
  input  logic                  mispredict,
  output logic                  initDone
);

  localparam int PHT_DEPTH = 2 ** PHT_WIDTH;

  logic [1:0]            pht [PHT_DEPTH];
  fsm_state_t            state_reg;
  logic [PHT_WIDTH-1:0]  sweep_reg;
  logic [PHT_WIDTH-1:0]  look_idx_reg;
  logic [HIST_WIDTH-1:0] hist_reg;
  logic                  look_valid_reg;
  logic [PHT_WIDTH-1:0]  look_idx;
  logic [PHT_WIDTH-1:0]  upd_idx;
  logic [HIST_WIDTH-1:0] ghr;
  logic                  accept;
  logic                  recover;
  logic                  unused_addr;

  assign unused_addr = ^{instrAddr[31:PHT_WIDTH+2], instrAddr[1:0],
                         updateInstr[31:PHT_WIDTH+2], updateInstr[1:0]};

  assign initDone = (state_reg == ST_RUN);
  assign accept   = readyIn & predValid & initDone;
  assign recover  = updateValid & mispredict & initDone;

`ifdef GSHARE_PREDICTOR_GHIST_EN
  assign look_idx = instrAddr[PHT_WIDTH+1:2] ^ PHT_WIDTH'(ghr);
  assign upd_idx  = updateInstr[PHT_WIDTH+1:2] ^ PHT_WIDTH'(updateHist);
`else
  assign look_idx = instrAddr[PHT_WIDTH+1:2];
  assign upd_idx  = updateInstr[PHT_WIDTH+1:2];
`endif

  // Read through the registered index so a same-cycle update is visible.
  assign jump     = look_valid_reg & pht[look_idx_reg][1];
  assign predHist = hist_reg;

  gshare_ghr #(
    .HIST_WIDTH(HIST_WIDTH)
  ) u_ghr (
    .clk          (clockIn),
    .rst          (resetIn),
    .shift_en     (readyIn & look_valid_reg),
    .shift_bit    (jump),
    .recover      (recover),
    .recover_hist (updateHist),
    .recover_taken(taken),
    .ghr          (ghr)
  );

  // PHT contents survive reset; the sweep rewrites every entry instead.
  always_ff @(posedge clockIn) begin
    if (!initDone) begin
      pht[sweep_reg] <= CNT_WNT;
    end else if (updateValid) begin
      pht[upd_idx] <= sat_next(pht[upd_idx], taken);
    end
  end

  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      state_reg      <= ST_INIT;
      sweep_reg      <= '0;
      look_idx_reg   <= '0;
      hist_reg       <= '0;
      look_valid_reg <= 1'b0;
    end else begin
      if (state_reg == ST_INIT) begin
        if (sweep_reg == '1) begin
          state_reg <= ST_RUN;
        end
        sweep_reg <= sweep_reg + PHT_WIDTH'(1);
      end
      if (accept) begin
        look_idx_reg <= look_idx;
        hist_reg     <= ghr;
      end
      if (recover) begin
        look_valid_reg <= 1'b0;
      end else if (accept) begin
        look_valid_reg <= 1'b1;
      end else if (readyIn) begin
        look_valid_reg <= 1'b0;
      end
    end
  end

endmodule
